// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 key event queue.
// Holds the prefix FSM state enum, the event bundle and byte classifiers.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_BAT   = 8'hAA;
    localparam logic [7:0] PS2_ACK   = 8'hFA;

    // Fake shift codes the keyboard wraps around some E0 keys
    localparam logic [7:0] PS2_FSH_L = 8'h12;
    localparam logic [7:0] PS2_FSH_R = 8'h59;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0,
        ST_SKIP
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       make;
        logic [7:0] code;
    } ps2_evt_t;

    // Keyboard status / protocol bytes that never start a key event
    function automatic logic ps2_is_status(input logic [7:0] b);
        return (b == 8'h00) || (b == PS2_BAT) || (b == PS2_ACK) ||
               (b == 8'hFC) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

    function automatic logic ps2_is_fake_shift(input logic [7:0] b);
        return (b == PS2_FSH_L) || (b == PS2_FSH_R);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word fall-through synchronous FIFO of ps2_evt_t entries.
// Ports: clk, rst_n, push_i/data_i (write), pop_i (read ack), data_o (head),
//   empty_o, full_o, level_o (entries stored). Push while full is accepted
//   only if a pop happens in the same cycle; DEPTH is a power of two >= 2.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push_i,
    input  ps2_evt_t       data_i,
    input  logic           pop_i,
    output ps2_evt_t       data_o,
    output logic           empty_o,
    output logic           full_o,
    output logic [LW-1:0]  level_o
);

    ps2_evt_t          mem_q [DEPTH];
    logic [AW-1:0]     wr_q, wr_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [LW-1:0]     lvl_q, lvl_d;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (lvl_q == '0);
    assign full_o  = (lvl_q == LW'(DEPTH));
    assign level_o = lvl_q;
    assign data_o  = mem_q[rd_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointers are AW bits wide, so they wrap modulo DEPTH by themselves
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        lvl_d = lvl_q;
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   lvl_d = lvl_q + 1'b1;
            2'b01:   lvl_d = lvl_q - 1'b1;
            default: lvl_d = lvl_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code decoder: prefix FSM (E0, F0, E0 F0, E1 Pause skip) feeding
// a valid/ready make/break event FIFO plus a 512-bit held-key bitmap.
// Ports: clk, rst_n, rx_byte/rx_valid (byte in), evt_valid/evt_ready/
//   evt_code/evt_ext/evt_make (event out), fifo_level, overflow_cnt,
//   query_ext/query_code/query_held (bitmap lookup).
// Build option: define PS2_REPEAT_FILTER_EN to drop typematic repeats and
//   breaks of keys not held before they reach the FIFO.
module ps2_key_event_queue
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int E1_SKIP     = 7,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_byte,
    input  logic          rx_valid,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [7:0]    evt_code,
    output logic          evt_ext,
    output logic          evt_make,
    output logic [LW-1:0] fifo_level,
    output logic [7:0]    overflow_cnt,
    input  logic          query_ext,
    input  logic [7:0]    query_code,
    output logic          query_held
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int SW = $clog2(E1_SKIP + 2);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [SW-1:0] SKIP_INIT = SW'(E1_SKIP);

    ps2_state_e     state_q, state_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [SW-1:0]  skip_q, skip_d;

    logic           emit;
    ps2_evt_t       evt;
    logic           pend_vld_q;
    ps2_evt_t       pend_q;

    logic [511:0]   held_q, held_d;
    logic [7:0]     ovf_q, ovf_d;

    logic           filt;
    logic           want_push;
    logic           pop;
    logic           full;
    logic           empty;
    ps2_evt_t       head;
    logic [8:0]     pend_idx;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            skip_q  <= skip_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte == PS2_EXT) begin
                        state_d = ST_E0;
                    end else if (rx_byte == PS2_BRK) begin
                        state_d = ST_F0;
                    end else if (rx_byte == PS2_PAUSE) begin
                        state_d = (E1_SKIP > 0) ? ST_SKIP : ST_IDLE;
                        skip_d  = SKIP_INIT;
                    end
                end
                ST_E0: begin
                    state_d = (rx_byte == PS2_BRK) ? ST_E0F0 : ST_IDLE;
                end
                ST_SKIP: begin
                    if (skip_q <= SW'(1)) begin
                        state_d = ST_IDLE;
                        skip_d  = '0;
                    end else begin
                        skip_d  = skip_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && tmo_q == TMO_LAST) begin
            // Abandoned prefix: forget it so the next byte starts fresh
            state_d = ST_IDLE;
            skip_d  = '0;
        end
    end

    // Idle timer only runs while a prefix is pending
    always_comb begin
        tmo_d = tmo_q + 1'b1;
        if (state_q == ST_IDLE || rx_valid || tmo_q == TMO_LAST) begin
            tmo_d = '0;
        end
    end

    // ---------------- FSM: outputs (event decode) ----------------
    always_comb begin
        emit     = 1'b0;
        evt.ext  = 1'b0;
        evt.make = 1'b1;
        evt.code = rx_byte;
        if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    emit = !ps2_is_status(rx_byte) &&
                           rx_byte != PS2_EXT &&
                           rx_byte != PS2_BRK &&
                           rx_byte != PS2_PAUSE;
                end
                ST_E0: begin
                    evt.ext = 1'b1;
                    emit    = rx_byte != PS2_BRK &&
                              !ps2_is_fake_shift(rx_byte);
                end
                ST_F0: begin
                    evt.make = 1'b0;
                    emit     = 1'b1;
                end
                ST_E0F0: begin
                    evt.ext  = 1'b1;
                    evt.make = 1'b0;
                    emit     = !ps2_is_fake_shift(rx_byte);
                end
                default: emit = 1'b0;
            endcase
        end
    end

    // Decoded event is staged one cycle before FIFO push / bitmap update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
        end else begin
            pend_vld_q <= emit;
            pend_q     <= evt;
        end
    end

    // ---------------- held-key bitmap ----------------
    assign pend_idx = {pend_q.ext, pend_q.code};

    always_comb begin
        held_d = held_q;
        if (pend_vld_q) begin
            held_d[pend_idx] = pend_q.make;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q <= '0;
        end else begin
            held_q <= held_d;
        end
    end

    assign query_held = held_q[{query_ext, query_code}];

    // ---------------- repeat filter ----------------
`ifdef PS2_REPEAT_FILTER_EN
    // Make of a held key or break of a released key carries no news
    assign filt = pend_vld_q && (pend_q.make == held_q[pend_idx]);
`else
    assign filt = 1'b0;
`endif

    // ---------------- FIFO and overflow ----------------
    assign want_push = pend_vld_q && !filt;
    assign pop       = evt_valid && evt_ready;

    always_comb begin
        ovf_d = ovf_q;
        if (want_push && full && !pop && ovf_q != 8'hFF) begin
            ovf_d = ovf_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (want_push),
        .data_i  (pend_q),
        .pop_i   (pop),
        .data_o  (head),
        .empty_o (empty),
        .full_o  (full),
        .level_o (fifo_level)
    );

    assign evt_valid    = !empty;
    assign evt_code     = evt_valid ? head.code : 8'h00;
    assign evt_ext      = evt_valid && head.ext;
    assign evt_make     = evt_valid && head.make;
    assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed bench for ps2_key_event_queue.
// Short timeout parameter keeps the prefix-expiry case fast.
module tb_ps2_key_event_queue;

    localparam int DEPTH = 8;
    localparam int TO    = 32;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          rx_valid = 1'b0;
    logic          evt_valid;
    logic          evt_ready = 1'b0;
    logic [7:0]    evt_code;
    logic          evt_ext;
    logic          evt_make;
    logic [LW-1:0] fifo_level;
    logic [7:0]    overflow_cnt;
    logic          query_ext = 1'b0;
    logic [7:0]    query_code = 8'h00;
    logic          query_held;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ps2_key_event_queue #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TO),
        .E1_SKIP     (7)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_ext      (evt_ext),
        .evt_make     (evt_make),
        .fifo_level   (fifo_level),
        .overflow_cnt (overflow_cnt),
        .query_ext    (query_ext),
        .query_code   (query_code),
        .query_held   (query_held)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the negedge right after the rx_valid cycle was sampled
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic put(input logic [7:0] b);
        send(b);
        idle(3);
    endtask

    task automatic query(input string tag, input logic e,
                         input logic [7:0] c, input logic exp);
        query_ext  = e;
        query_code = c;
        #1;
        chk(tag, {31'd0, query_held}, {31'd0, exp});
    endtask

    // Wait (bounded) for the head, compare {ext,make,code}, then pop it
    task automatic pop_exp(input string tag, input logic e,
                           input logic m, input logic [7:0] c);
        int n = 0;
        while (!evt_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!evt_valid) begin
            chk({tag, "_wait"}, 32'd0, 32'd1);
        end else begin
            chk(tag, {22'd0, evt_ext, evt_make, evt_code},
                {22'd0, e, m, c});
            evt_ready = 1'b1;
            @(negedge clk);
            evt_ready = 1'b0;
        end
    endtask

    int exp_n;

    initial begin
        idle(2);
        chk("rst_valid", {31'd0, evt_valid}, 0);
        chk("rst_code", {24'd0, evt_code}, 0);
        chk("rst_level", {28'd0, fifo_level}, 0);
        chk("rst_ovf", {24'd0, overflow_cnt}, 0);
        query("rst_held", 1'b0, 8'h1C, 1'b0);
        rst_n = 1'b1;
        idle(2);

        // Plain make then break; event visible two edges after the byte
        send(8'h1C);
        @(negedge clk);
        chk("lat_valid", {31'd0, evt_valid}, 1);
        query("held_1c", 1'b0, 8'h1C, 1'b1);
        pop_exp("mk_1c", 1'b0, 1'b1, 8'h1C);
        query("held_1c_b", 1'b0, 8'h1C, 1'b1);
        put(8'hF0);
        put(8'h1C);
        pop_exp("bk_1c", 1'b0, 1'b0, 8'h1C);
        query("rel_1c", 1'b0, 8'h1C, 1'b0);

        // Extended key make/break
        put(8'hE0);
        put(8'h75);
        query("held_e75", 1'b1, 8'h75, 1'b1);
        query("held_n75", 1'b0, 8'h75, 1'b0);
        pop_exp("mk_e75", 1'b1, 1'b1, 8'h75);
        put(8'hE0);
        put(8'hF0);
        put(8'h75);
        pop_exp("bk_e75", 1'b1, 1'b0, 8'h75);
        query("rel_e75", 1'b1, 8'h75, 1'b0);
        query("rel_n75", 1'b0, 8'h75, 1'b0);

        // Fake shifts and status bytes produce nothing
        put(8'hE0);
        put(8'h12);
        put(8'hE0);
        put(8'hF0);
        put(8'h59);
        put(8'hAA);
        put(8'hFA);
        put(8'h00);
        chk("fake_lvl", {28'd0, fifo_level}, 0);

        // Pause sequence swallowed, following key decoded normally
        put(8'hE1);
        put(8'h14);
        put(8'h77);
        put(8'hE1);
        put(8'hF0);
        put(8'h14);
        put(8'hF0);
        put(8'h77);
        put(8'h29);
        chk("pause_lvl", {28'd0, fifo_level}, 1);
        pop_exp("mk_29", 1'b0, 1'b1, 8'h29);

        // Stale F0 prefix expires; next byte is a make
        put(8'hF0);
        idle(TO + 4);
        put(8'h1D);
        pop_exp("tmo_1d", 1'b0, 1'b1, 8'h1D);
        put(8'hF0);
        put(8'h1D);
        pop_exp("tmo_bk", 1'b0, 1'b0, 8'h1D);

        // Overflow: 10 makes into 8 entries
        for (int i = 1; i <= 10; i++) begin
            put(8'(i));
        end
        chk("ovf_lvl", {28'd0, fifo_level}, 8);
        chk("ovf_cnt", {24'd0, overflow_cnt}, 2);
        query("ovf_held", 1'b0, 8'h0A, 1'b1);
        // Push lands on the same edge as a pop of the full FIFO
        send(8'h0B);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        idle(2);
        chk("pp_lvl", {28'd0, fifo_level}, 8);
        chk("pp_ovf", {24'd0, overflow_cnt}, 2);
        for (int i = 2; i <= 8; i++) begin
            pop_exp("drain", 1'b0, 1'b1, 8'(i));
        end
        pop_exp("drain_0b", 1'b0, 1'b1, 8'h0B);
        chk("drain_lvl", {28'd0, fifo_level}, 0);

        // Typematic repeats
        put(8'h1C);
        put(8'h1C);
        put(8'h1C);
        put(8'hF0);
        put(8'h1C);
`ifdef PS2_REPEAT_FILTER_EN
        exp_n = 2;
`else
        exp_n = 4;
`endif
        chk("rep_lvl", {28'd0, fifo_level}, exp_n);
        pop_exp("rep_first", 1'b0, 1'b1, 8'h1C);
        for (int i = 1; i < exp_n - 1; i++) begin
            pop_exp("rep_mid", 1'b0, 1'b1, 8'h1C);
        end
        pop_exp("rep_last", 1'b0, 1'b0, 8'h1C);

        // Reset mid-prefix drops the F0
        put(8'hF0);
        rst_n = 1'b0;
        idle(2);
        chk("rr_ovf", {24'd0, overflow_cnt}, 0);
        query("rr_held", 1'b0, 8'h0A, 1'b0);
        rst_n = 1'b1;
        idle(2);
        put(8'h2A);
        pop_exp("rr_2a", 1'b0, 1'b1, 8'h2A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_queue.md
Name: ps2_key_event_queue

Overview:
- Parametrised successor to the single-register PS/2 scan-code tracker.
- Consumes complete PS/2 bytes from the byte receiver and runs a full prefix FSM covering E0, F0, E0 F0 and the E1 Pause sequence.
- Emits make/break events into a valid/ready event FIFO and keeps a held-key bitmap that game logic can query.
- Sits between the PS/2 byte receiver and the Tetris input controller, so no keypress is lost between frames.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, minimum 2.
- TIMEOUT_CYC, 100000, idle clk cycles after which a pending prefix is discarded (1 ms at 100 MHz).
- E1_SKIP, 7, bytes discarded after an E1 lead byte (Pause make sequence).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_byte  in  8  received PS/2 byte
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head
- evt_code  out  8  head scan code
- evt_ext  out  1  head is an E0-extended key
- evt_make  out  1  1 = press, 0 = release
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries stored
- overflow_cnt  out  8  dropped events, saturating at 255
- query_ext  in  1  bitmap query, extended flag
- query_code  in  8  bitmap query, scan code
- query_held  out  1  key {query_ext,query_code} currently held

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM in IDLE; FIFO empty.
  - evt_valid=0, evt_code=0, evt_ext=0, evt_make=0.
  - fifo_level=0, overflow_cnt=0, all 512 bitmap bits=0, timeout counter=0.
  - Reset mid-sequence discards any partial prefix.
- FSM states: IDLE, E0, F0, E0F0, SKIP. Bytes act only when rx_valid=1.
  - IDLE:
    - E0 -> E0; F0 -> F0; E1 -> SKIP with skip count E1_SKIP.
    - 00, AA, FA, FC, FE, FF are ignored and stay in IDLE.
    - Any other byte x emits make {ext=0, code=x} and stays in IDLE.
  - E0:
    - F0 -> E0F0.
    - 12 or 59 (fake shifts) are discarded -> IDLE.
    - Any other byte x emits make {ext=1, code=x} -> IDLE.
  - F0: byte x emits break {0,x} -> IDLE.
  - E0F0: byte x emits break {1,x} -> IDLE, except 12/59, which are discarded -> IDLE.
  - SKIP: decrement the count on each byte; return to IDLE after the last byte. No events are emitted.
- Timeout:
  - In any state other than IDLE, the counter increments each cycle without rx_valid and clears on rx_valid.
  - When the counter reaches TIMEOUT_CYC-1, the FSM returns to IDLE and the counter clears.
  - The counter is held at 0 while in IDLE.
- Event emission:
  - Enqueue and bitmap update occur on the clk edge after the rx_valid cycle.
  - evt_valid rises one cycle later (2-cycle latency from byte to visible event when the FIFO is empty).
  - The bitmap is set on make and cleared on break, including when the FIFO drops the event.
- FIFO:
  - First-word fall-through; pop when evt_valid && evt_ready.
  - Outputs are stable while evt_valid=1 && evt_ready=0.
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - Otherwise the event is dropped and overflow_cnt increments, saturating at 255.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- query_held is a combinational read of the bitmap. It reflects an update on the cycle after the update edge.

Optional Feature:
- Macro: PS2_REPEAT_FILTER_EN.
- Defined:
  - A make event for a key whose bitmap bit is already 1 (typematic repeat) is not enqueued.
  - A break event for a key whose bit is 0 is not enqueued.
  - Filtered events do not count as overflow.
- Undefined: every decoded event is enqueued, including typematic repeats.

Decomposition:
- Package ps2_pkg:
  - Byte constants PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1, PS2_BAT=AA, PS2_ACK=FA.
  - typedef enum ps2_state_e for the five FSM states.
  - typedef packed struct ps2_evt_t {ext, make, code[7:0]} (10 bits).
- Sub-module: ps2_evt_fifo, a generic FWFT sync FIFO of ps2_evt_t, parametrised by depth, exposing level and full.

Test Plan:
- Bytes 1C, F0 1C -> events {0,make,1C}, {0,brk,1C}; query 1C held between them, released after.
- Bytes E0 75, E0 F0 75 -> {1,make,75}, {1,brk,75}; query {1,75} held, then clear; {0,75} never set.
- Bytes E1 14 77 E1 F0 14 F0 77, then 29 -> only {0,make,29} emitted.
- Byte F0, then 100000 idle cycles, then 1D -> {0,make,1D}, not a break.
- evt_ready=0, FIFO_DEPTH=8, 10 make events -> fifo_level=8, overflow_cnt=2, first 8 events retained in order; push+pop while full keeps level at 8.
- 1C 1C 1C F0 1C -> 4 events without the macro; 2 events with PS2_REPEAT_FILTER_EN.
